// File: rtl/i2s_clk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clk_sched
//  Purpose  : I2S BCLK/LRCLK generator with frame-aligned divider changes and
//             frame-aligned start/stop, plus bit/frame strobes for the shifter.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_sched #(
    parameter int          WORD_BITS = 16,
    parameter logic [7:0]  DIV_RESET = 8'd8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [7:0]                       div_in,
    input  logic                             div_req,
    output logic                             div_ack,
    output logic                             div_busy,
    output logic                             bclk,
    output logic                             lrclk,
    output logic                             bit_stb,
    output logic                             frame_stb,
    output logic [$clog2(2*WORD_BITS)-1:0]   bit_idx,
    output logic                             running
);

    localparam int             IW      = $clog2(2*WORD_BITS);
    localparam logic [IW-1:0]  C_LAST  = IW'(2*WORD_BITS-1);
    localparam logic [0:0]     S_IDLE  = 1'b0;
    localparam logic [0:0]     S_RUN   = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [7:0]     act_div_q, act_div_d;
    logic [7:0]     pend_div_q, pend_div_d;
    logic           busy_q, busy_d;
    logic           ack_q, ack_d;
    logic [6:0]     hc_q, hc_d;
    logic           bclk_q, bclk_d;
    logic           lrclk_q, lrclk_d;
    logic           bit_stb_q, bit_stb_d;
    logic           frame_stb_q, frame_stb_d;
    logic [IW-1:0]  bit_idx_q, bit_idx_d;
    logic           running_q, running_d;

    logic           w_half_end;
    logic           w_fall;
    logic           w_last;
    logic           w_boundary;
    logic           w_xfer;
    logic           w_cap;

    // H-1 equals D>>1, so the half-period ends when hc reaches act_div[7:1]
    assign w_half_end = (hc_q == act_div_q[7:1]);
    assign w_fall     = (state_q == S_RUN) && w_half_end && bclk_q;
    assign w_last     = (bit_idx_q == C_LAST);
    assign w_boundary = w_fall && w_last;
    assign w_xfer     = busy_q && ((state_q == S_IDLE) || w_boundary);
    assign w_cap      = div_req && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_div_q   <= DIV_RESET;
            pend_div_q  <= 8'd0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            hc_q        <= 7'd0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            bit_stb_q   <= 1'b0;
            frame_stb_q <= 1'b0;
            bit_idx_q   <= '0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_div_q   <= act_div_d;
            pend_div_q  <= pend_div_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            hc_q        <= hc_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            bit_stb_q   <= bit_stb_d;
            frame_stb_q <= frame_stb_d;
            bit_idx_q   <= bit_idx_d;
            running_q   <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (w_boundary && !en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hc_d        = 7'd0;
        bclk_d      = 1'b0;
        bit_idx_d   = '0;
        bit_stb_d   = 1'b0;
        frame_stb_d = 1'b0;
        running_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    running_d   = 1'b1;
                    bit_stb_d   = 1'b1;
                    frame_stb_d = 1'b1;
                end
            end
            S_RUN: begin
                running_d = 1'b1;
                hc_d      = w_half_end ? 7'd0 : hc_q + 7'd1;
                bclk_d    = w_half_end ? ~bclk_q : bclk_q;
                bit_idx_d = bit_idx_q;
                if (w_fall) begin
                    bit_stb_d = 1'b1;
                    if (!w_last) begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end else begin
                        bit_idx_d = '0;
                        if (en) begin
                            frame_stb_d = 1'b1;
                        end else begin
                            // stop lands where the next frame would have begun
                            bit_stb_d = 1'b0;
                            running_d = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
        lrclk_d = bit_idx_d[IW-1];

        // a pending request is applied before a same-cycle new one can be taken
        act_div_d  = w_xfer ? pend_div_q : act_div_q;
        pend_div_d = w_cap  ? div_in     : pend_div_q;
        busy_d     = w_cap | (busy_q & ~w_xfer);
        ack_d      = w_xfer;
    end

    assign div_ack   = ack_q;
    assign div_busy  = busy_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign bit_stb   = bit_stb_q;
    assign frame_stb = frame_stb_q;
    assign bit_idx   = bit_idx_q;
    assign running   = running_q;

endmodule
`default_nettype wire

// File: doc/i2s_clk_sched.md
# i2s_clk_sched

Sequences the I2S serial clocks: generates bit clock (BCLK) and word-select (LRCLK) from the system clock with a programmable, frame-synchronous divider. It also emits bit and frame strobes that drive the sample shifter. Divider changes are requested through a req/ack handshake and take effect only on a frame boundary, so no BCLK glitch or short frame ever reaches the codec. Start and stop are likewise frame-aligned.

## Interface
- WORD_BITS, 16, BCLK periods per channel; frame = 2*WORD_BITS bits; must be a power of two, ≥2
- DIV_RESET, 8, divider value loaded at reset
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run request; level-sensitive
- div_in  in  8  requested divider D; BCLK half-period H = (D>>1)+1 clk cycles
- div_req  in  1  load request for div_in
- div_ack  out  1  one-cycle pulse: requested divider now active
- div_busy  out  1  a divider request is pending
- bclk  out  1  bit clock, registered
- lrclk  out  1  word select: 0 = left, 1 = right, registered
- bit_stb  out  1  one-cycle pulse at start of each bit (bclk falling / start)
- frame_stb  out  1  one-cycle pulse at start of each frame, coincident with bit_stb
- bit_idx  out  $clog2(2*WORD_BITS)  index of the current bit within the frame
- running  out  1  1 while a frame is in progress

## Operation
- Registers: active divider act_div (8b), pending divider pend_div plus pend flag, half-count hc (7b), bit counter bit_idx, FSM state.
- States: IDLE, RUN.
- IDLE: bclk=0, lrclk=0, hc=0, bit_idx=0, running=0.
  - en=1 → RUN next cycle. First RUN cycle: frame_stb=bit_stb=1, bit_idx=0, running=1.
- RUN:
  - hc counts 0..H-1 with H=(act_div>>1)+1. At hc==H-1: hc←0 and bclk toggles; otherwise hc increments.
  - On a 1→0 bclk toggle (falling edge):
    - bit_stb pulses in the first cycle bclk is low.
    - If bit_idx < 2*WORD_BITS-1: bit_idx increments.
    - Otherwise, frame boundary: bit_idx←0. If en=1, frame_stb pulses with bit_stb. If en=0, go to IDLE; no strobes, running←0.
  - lrclk = (bit_idx ≥ WORD_BITS), updated in the same cycle as bit_idx.
- Divider handshake:
  - div_req=1 while div_busy=0: pend_div←div_in, div_busy←1 next cycle.
  - div_req while div_busy=1 is ignored. The requester waits for div_ack.
  - In IDLE: pending divider moves to act_div one cycle after capture; div_ack pulses and div_busy clears in the same cycle.
  - In RUN: transfer only at a frame boundary. act_div is updated in the boundary cycle; the new H applies from the next hc cycle; div_ack pulses in the boundary cycle.
  - Boundary and a fresh div_req in the same cycle: the already-pending value transfers and the new request is ignored (busy was 1). If nothing was pending, the request is captured and waits for the next boundary.
- D=0 and D=1 both give H=1 (BCLK = clk/2). D=255 gives H=128 (7-bit hc sufficient).
- en deassertion mid-frame never truncates a frame. en re-asserted before the boundary cancels the stop.

## Timing
- Reset values: bclk 0, lrclk 0, bit_stb 0, frame_stb 0, bit_idx 0, div_ack 0, div_busy 0, running 0. act_div=DIV_RESET; pending cleared; FSM=IDLE.
- Reset is synchronous and overrides everything, including mid-frame. Outputs reach reset values on the first clk edge with rst_n=0.
- Start latency: en sampled high in IDLE → running/frame_stb high on the next cycle.
- BCLK period = 2H clk; frame = 2*WORD_BITS*2H clk.
- Stop: running falls in the cycle the final falling edge would have occurred; bclk is already 0.

## Test plan
- WORD_BITS=4, reset, en=1, default D=8 (H=5) → bclk period 10 clk, frame_stb every 80 clk, lrclk high for bit_idx 4..7 (40 clk), bit_stb every 10 clk.
- D=0 via req in IDLE → div_ack one cycle after capture; run → bclk = clk/2, frame = 16 clk.
- Running D=8, req D=2 at bit_idx 2 → div_busy high until frame boundary; div_ack on boundary; next frame bclk period 4 clk; no short/long half-period at the switch.
- Second div_req while div_busy → ignored; the first value is the one applied; div_ack pulses once.
- en dropped at bit_idx 5 → frame completes through bit 7; IDLE at boundary with bclk=0, lrclk=0, running=0, no frame_stb.
- rst_n low mid-frame for one cycle → all outputs zero next edge; act_div=DIV_RESET; restart produces a full first frame.
